// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
//
// Bit-timing and sampling stage of the UART receiver. Counts oversampling
// edges inside each bit period, takes a 3-sample majority vote around mid-bit
// and presents the resolved bit with a one-cycle strobe. Bit and frame
// boundary pulses are provided for the RX control FSM.
//
// Optional feature macro: UART_RX_SYNC_EN
//   defined   : rx_in passes through a two-flop synchronizer (reset to 1)
//               before sampling; line-to-sample latency grows by 2 cycles.
//   undefined : rx_in is sampled directly (caller keeps it synchronous).
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   rx_in        in   serial line, idles high
//   prescale     in   oversampling ratio (even, 4..32), stable while enabled
//   enable       in   counting enable, high for the whole frame
//   sampled_bit  out  majority-voted bit value
//   sample_valid out  strobe: sampled_bit has just been updated
//   start_glitch out  strobe: start bit resolved to 1 (false start)
//   bit_done     out  strobe: end of a bit period
//   frame_done   out  strobe: end of bit FRAME_BITS-1
//   edge_cnt     out  edge index within the bit, 0..prescale-1
//   bit_cnt      out  bit index within the frame, 0..FRAME_BITS-1
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
  parameter int FRAME_BITS     = 11,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      enable,
  output logic                      sampled_bit,
  output logic                      sample_valid,
  output logic                      start_glitch,
  output logic                      bit_done,
  output logic                      frame_done,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);
  localparam logic [3:0]                LAST_BIT = 4'(FRAME_BITS - 1);

  // 3-input majority used for the mid-bit vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // ---------------------------------------------------------------------------
  // Line conditioning
  // ---------------------------------------------------------------------------
  logic rxs;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], rx_in};
  end

  // Both stages reset to the idle line level so no false start is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rxs = sync_q[1];
`else
  assign rxs = rx_in;
`endif

  // ---------------------------------------------------------------------------
  // Bit timing, sampling and vote
  // ---------------------------------------------------------------------------
  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [3:0]                bit_cnt_q, bit_cnt_d;
  logic                      s0_q, s0_d;
  logic                      s1_q, s1_d;
  logic                      sampled_bit_q, sampled_bit_d;
  logic                      sample_valid_q, sample_valid_d;
  logic                      start_glitch_q, start_glitch_d;
  logic                      bit_done_q, bit_done_d;
  logic                      frame_done_q, frame_done_d;

  logic [PRESCALE_WIDTH-1:0] mid;
  logic [PRESCALE_WIDTH-1:0] mid_m1;
  logic [PRESCALE_WIDTH-1:0] mid_p1;
  logic [PRESCALE_WIDTH-1:0] last_edge;
  logic                      vote;

  assign mid       = prescale >> 1;
  assign mid_m1    = mid - ONE;
  assign mid_p1    = mid + ONE;
  assign last_edge = prescale - ONE;
  // Third sample is taken live from rxs in the vote cycle.
  assign vote      = maj3(s0_q, s1_q, rxs);

  always_comb begin
    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    s0_d           = s0_q;
    s1_d           = s1_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    start_glitch_d = 1'b0;
    bit_done_d     = 1'b0;
    frame_done_d   = 1'b0;

    if (!enable) begin
      // Dropping enable always wins over any vote or boundary in this cycle;
      // sampled_bit keeps the last resolved value.
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      s0_d       = 1'b0;
      s1_d       = 1'b0;
    end else begin
      if (edge_cnt_q == last_edge) begin
        edge_cnt_d = '0;
        bit_done_d = 1'b1;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d    = '0;
          frame_done_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end else begin
        edge_cnt_d = edge_cnt_q + ONE;
      end

      if (edge_cnt_q == mid_m1) begin
        s0_d = rxs;
      end
      if (edge_cnt_q == mid) begin
        s1_d = rxs;
      end
      // At prescale 4 the vote edge is also the last edge; both fire.
      if (edge_cnt_q == mid_p1) begin
        sampled_bit_d  = vote;
        sample_valid_d = 1'b1;
        start_glitch_d = (bit_cnt_q == 4'd0) && vote;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      start_glitch_q <= 1'b0;
      bit_done_q     <= 1'b0;
      frame_done_q   <= 1'b0;
    end else begin
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      start_glitch_q <= start_glitch_d;
      bit_done_q     <= bit_done_d;
      frame_done_q   <= frame_done_d;
    end
  end

  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;
  assign start_glitch = start_glitch_q;
  assign bit_done     = bit_done_q;
  assign frame_done   = frame_done_q;
  assign edge_cnt     = edge_cnt_q;
  assign bit_cnt      = bit_cnt_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
module tb_uart_rx_sampler;

  localparam int FB = 11;
  localparam int PW = 6;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_in;
  logic [PW-1:0] prescale;
  logic          enable;
  logic          sampled_bit;
  logic          sample_valid;
  logic          start_glitch;
  logic          bit_done;
  logic          frame_done;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;

  always #5 clk = ~clk;

  uart_rx_sampler #(.FRAME_BITS(FB), .PRESCALE_WIDTH(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_in        (rx_in),
    .prescale     (prescale),
    .enable       (enable),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .start_glitch (start_glitch),
    .bit_done     (bit_done),
    .frame_done   (frame_done),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt)
  );

  typedef struct {
    bit val;
    bit glitch;
    int ecnt;
    int bcnt;
  } samp_t;

  typedef struct {
    bit frame;
    int bcnt;
  } bitd_t;

  samp_t sq[$];
  bitd_t bq[$];
  bit    line_q[$];   // rx_in value presented before each enabled edge

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Line value seen by the voter at enabled edge j (idle high before frame).
  function automatic bit rxs_at(input int j);
    if (j - LAT < 0) return 1'b1;
    return line_q[j - LAT];
  endfunction

  // ---------------- monitor ----------------
  samp_t mon_s;
  bitd_t mon_b;
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (sample_valid) begin
        if (sq.size() == 0) chk("unexpected sample_valid", 1, 0);
        else begin
          mon_s = sq.pop_front();
          chk("sampled_bit", sampled_bit, mon_s.val);
          chk("start_glitch", start_glitch, mon_s.glitch);
          chk("edge_cnt_at_sample", edge_cnt, mon_s.ecnt);
          chk("bit_cnt_at_sample", bit_cnt, mon_s.bcnt);
        end
      end else if (start_glitch) begin
        chk("start_glitch_without_sample", 1, 0);
      end
      if (bit_done) begin
        if (bq.size() == 0) chk("unexpected bit_done", 1, 0);
        else begin
          mon_b = bq.pop_front();
          chk("frame_done", frame_done, mon_b.frame);
          chk("bit_cnt_at_bit_done", bit_cnt, mon_b.bcnt);
        end
      end else if (frame_done) begin
        chk("frame_done_without_bit_done", 1, 0);
      end
    end
  end

  // ---------------- driver + reference model ----------------
  // Runs nedges enabled edges of line_q at prescale p, then drops enable
  // (or asserts reset when do_reset is set).
  task automatic run(input int p, input int nedges, input bit do_reset);
    int    mid;
    int    cnt;
    bit    last_v;
    bit    have_v;
    samp_t s;
    bitd_t d;
    mid    = p / 2;
    have_v = 1'b0;
    last_v = 1'b0;
    for (int b = 0; b < FB; b++) begin
      int base;
      base = b * p;
      if (base + mid + 1 < nedges) begin
        cnt = int'(rxs_at(base + mid - 1)) + int'(rxs_at(base + mid)) + int'(rxs_at(base + mid + 1));
        s.val    = (cnt >= 2);
        s.glitch = (b == 0) && (cnt >= 2);
        s.ecnt   = (mid + 2) % p;
        s.bcnt   = (mid + 1 == p - 1) ? (b + 1) % FB : b;
        sq.push_back(s);
        last_v = s.val;
        have_v = 1'b1;
      end
      if (base + p - 1 < nedges) begin
        d.frame = (b == FB - 1);
        d.bcnt  = (b + 1) % FB;
        bq.push_back(d);
      end
    end
    prescale = PW'(p);
    for (int j = 0; j < nedges; j++) begin
      @(negedge clk);
      enable = 1'b1;
      rx_in  = line_q[j];
    end
    @(negedge clk);
    chk("edge_cnt_position", edge_cnt, nedges % p);
    chk("bit_cnt_position", bit_cnt, (nedges / p) % FB);
    if (do_reset) begin
      #2;
      reset  = 1'b1;
      enable = 1'b0;
      rx_in  = 1'b1;
      #1;
      chk("rst_sampled_bit", sampled_bit, 1);
      chk("rst_sample_valid", sample_valid, 0);
      chk("rst_start_glitch", start_glitch, 0);
      chk("rst_bit_done", bit_done, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_edge_cnt", edge_cnt, 0);
      chk("rst_bit_cnt", bit_cnt, 0);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      enable = 1'b0;
      rx_in  = 1'b1;
      @(negedge clk);
      chk("edge_cnt_cleared", edge_cnt, 0);
      chk("bit_cnt_cleared", bit_cnt, 0);
      chk("no_sample_after_disable", sample_valid, 0);
    end
    repeat (4) @(negedge clk);
    if (!do_reset && have_v) chk("sampled_bit_hold", sampled_bit, last_v);
  endtask

  task automatic fill_bits(input int p, input bit bits[FB]);
    line_q.delete();
    for (int b = 0; b < FB; b++)
      for (int c = 0; c < p; c++) line_q.push_back(bits[b]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit bits[FB];
    int p;
    reset    = 1'b1;
    enable   = 1'b0;
    rx_in    = 1'b1;
    prescale = PW'(8);
    repeat (3) @(negedge clk);
    chk("init_sampled_bit", sampled_bit, 1);
    chk("init_sample_valid", sample_valid, 0);
    chk("init_bit_done", bit_done, 0);
    chk("init_frame_done", frame_done, 0);
    chk("init_start_glitch", start_glitch, 0);
    chk("init_edge_cnt", edge_cnt, 0);
    chk("init_bit_cnt", bit_cnt, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean frame: start 0, 0x5A LSB first, parity 0, stop 1.
    bits = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 0, 1};
    fill_bits(8, bits);
    run(8, FB * 8, 1'b0);

    // Majority vote at prescale 16: rxs 1,0,1 in bit 1 and 0,1,0 in bit 2.
    bits = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    fill_bits(16, bits);
    line_q[16 + 7 - LAT] = 1'b1;
    line_q[16 + 8 - LAT] = 1'b0;
    line_q[16 + 9 - LAT] = 1'b1;
    line_q[32 + 7 - LAT] = 1'b0;
    line_q[32 + 8 - LAT] = 1'b1;
    line_q[32 + 9 - LAT] = 1'b0;
    run(16, FB * 16, 1'b0);

    // False start: line low for 2 cycles then high; frame keeps running.
    bits = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    fill_bits(8, bits);
    line_q[0] = 1'b0;
    line_q[1] = 1'b0;
    run(8, FB * 8, 1'b0);

    // Enable collision: enable drops in the bit-3 vote cycle.
    for (int b = 0; b < FB; b++) bits[b] = 1'($urandom_range(0, 1));
    bits[0] = 1'b0;
    fill_bits(8, bits);
    run(8, 3 * 8 + 5, 1'b0);

    // Reset mid-count at edge_cnt 5, bit_cnt 3 with sampled_bit 0.
    bits = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    fill_bits(8, bits);
    run(8, 3 * 8 + 5, 1'b1);

    // Prescale 32: start-bit line edge 2 cycles before edge 15.
    for (int b = 0; b < FB; b++) bits[b] = 1'($urandom_range(0, 1));
    bits[FB - 1] = 1'b1;
    bits[0]      = 1'b1;
    fill_bits(32, bits);
    for (int c = 13; c < 32; c++) line_q[c] = 1'b0;
    run(32, FB * 32, 1'b0);

    // Randomized frames with noise around the sample points.
    for (int f = 0; f < 12; f++) begin
      p = 2 * int'($urandom_range(2, 16));
      for (int b = 0; b < FB; b++) bits[b] = 1'($urandom_range(0, 1));
      bits[0]      = ($urandom_range(0, 4) == 0);
      bits[FB - 1] = 1'b1;
      fill_bits(p, bits);
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = int'($urandom_range(0, 2)) + (p / 2 - 1) + p * int'($urandom_range(0, FB - 1));
        line_q[idx] = ~line_q[idx];
      end
      run(p, FB * p, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("sample_queue_drained", sq.size(), 0);
    chk("bit_done_queue_drained", bq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Oversampling bit-timing and sampling stage of the UART receiver. It sits directly upstream of the deserializer. It counts oversampling edges within each bit period, takes a 3-sample majority vote around mid-bit, and emits a resolved serial bit with a one-cycle strobe. It also emits bit and frame boundary pulses for the RX control FSM, which gates the strobe into the deserializer's `deser_en`.

## Interface
- `FRAME_BITS`, default 11: bits per frame (start + data + parity + stop); `bit_cnt` wraps after `FRAME_BITS-1`.
- `PRESCALE_WIDTH`, default 6: width of `prescale` and `edge_cnt`.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_in`  in  1  serial line; idles high.
- `prescale`  in  `PRESCALE_WIDTH`  oversampling ratio; legal values are even, 4..32.
- `enable`  in  1  counting enable from the RX FSM; high for the whole frame.
- `sampled_bit`  out  1  majority-voted bit value.
- `sample_valid`  out  1  one-cycle strobe: `sampled_bit` has just been updated.
- `start_glitch`  out  1  one-cycle strobe: the start bit resolved to 1 (false start).
- `bit_done`  out  1  one-cycle strobe at the end of each bit period.
- `frame_done`  out  1  one-cycle strobe at the end of bit `FRAME_BITS-1`.
- `edge_cnt`  out  `PRESCALE_WIDTH`  current edge index within the bit, 0..`prescale-1`.
- `bit_cnt`  out  4  current bit index within the frame, 0..`FRAME_BITS-1`.

## Operation
- All outputs are registered.
- Reset values: `sampled_bit`=1; `edge_cnt`=0; `bit_cnt`=0; `sample_valid`, `start_glitch`, `bit_done`, `frame_done` all 0.
- Define `mid = prescale >> 1`. Let `rxs` be the line value after the optional synchronizer (see Configuration).
- `enable`=0:
  - `edge_cnt`, `bit_cnt` and the vote registers `s0`/`s1` clear to 0 on the next edge.
  - All strobes are 0.
  - `sampled_bit` holds its value.
- `enable`=1, each clock:
  - `edge_cnt` increments.
  - When `edge_cnt == prescale-1`: `edge_cnt` becomes 0 and `bit_done` is 1 next cycle.
  - At that same point `bit_cnt` increments, or becomes 0 if it equals `FRAME_BITS-1`. In the wrapping case `frame_done` is also 1 next cycle.
- Sampling:
  - At `edge_cnt == mid-1`, capture `rxs` into `s0`.
  - At `edge_cnt == mid`, capture `rxs` into `s1`.
  - At `edge_cnt == mid+1`: `sampled_bit <= maj(s0, s1, rxs)` and `sample_valid <= 1`.
- Glitch check: if `bit_cnt == 0` at the vote and the vote result is 1, `start_glitch` pulses in the same cycle as `sample_valid`.
  - The block does not stop itself; the FSM drops `enable`.
- `enable` falling in the same cycle as a vote, bit end or frame end: `enable` wins. No strobe is asserted and the counters clear.
- `prescale` must be stable while `enable`=1; behaviour on a change mid-frame is undefined.
- Illegal `prescale` values (odd, <4, >32) are outside the contract.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). Operation resumes only after `reset` deasserts and `enable` is high.

## Timing
- With `edge_cnt`=0 at cycle 0 of a bit:
  - `sample_valid` is high in cycle `mid+2`.
  - `bit_done` is high in cycle 0 of the following bit, i.e. one cycle after `edge_cnt == prescale-1`.
- Vote latency: 1 cycle after the third sample.
- Per bit: exactly one `sample_valid` and one `bit_done`.
- Per frame: `FRAME_BITS` sample strobes and one `frame_done`, coincident with the last `bit_done`.
- First count: the clock edge at which `enable` is first seen high moves `edge_cnt` from 0 to 1.

## Configuration
- Macro: `UART_RX_SYNC_EN`.
- Defined:
  - `rx_in` passes through a two-flop synchronizer (both flops reset to 1) to form `rxs`.
  - Line-to-sample latency grows by 2 cycles.
- Undefined:
  - `rxs = rx_in` directly; the caller guarantees `rx_in` is synchronous to `clk`.
  - All other behaviour is identical.

## Test plan
- Reset check: assert `reset` mid-count (`edge_cnt`=5, `bit_cnt`=3) → all outputs return to reset values in the same cycle; `sampled_bit`=1.
- Clean frame: `prescale`=8, `FRAME_BITS`=11, frame 0,0x5A LSB-first, parity 0, stop 1 → 11 `sample_valid` strobes, each at `edge_cnt` 6, carrying 0,0,1,0,1,1,0,1,0,0,1; `frame_done` coincides with the 11th `bit_done`.
- Majority vote: `prescale`=16, drive `rxs`=1,0,1 at edges 7,8,9 → `sampled_bit`=1; drive 0,1,0 → `sampled_bit`=0.
- False start: `prescale`=8, line low for 2 cycles then high → `start_glitch`=1 with `sample_valid` at bit 0; no `bit_done` suppression.
- Enable collision: drop `enable` in the cycle where `edge_cnt == mid+1` → no `sample_valid`; `edge_cnt`=0 and `bit_cnt`=0 next cycle.
- Prescale 32 with `UART_RX_SYNC_EN`: a line edge placed 2 cycles before edge 15 is resolved into the vote; the first `sample_valid` occurs at cycle 18 of the bit.
